// File: rtl/vrased_rst_ctrl_if.sv
// Bundle of the VRASED violation inputs, CPU PC and the reset-controller outputs.
interface vrased_rst_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             viol;
  logic [5:0]       viol_src;
  logic [15:0]      pc;
  logic             cause_clr;
  logic             puc_req;
  logic [5:0]       cause;
  logic             fetch_to;
  logic [CNT_W-1:0] viol_cnt;
  logic [1:0]       state;

  // Driver side: monitor/CPU/debug host.
  modport master (
    output viol, viol_src, pc, cause_clr,
    input  puc_req, cause, fetch_to, viol_cnt, state
  );

  // Reset controller side.
  modport slave (
    input  viol, viol_src, pc, cause_clr,
    output puc_req, cause, fetch_to, viol_cnt, state
  );
endinterface

// File: rtl/vrased_rst_ctrl.sv
// Turns VRASED violations into a stretched PUC request, confirms the CPU
// restarts at the reset handler, and keeps sticky cause / event-count state.
module vrased_rst_ctrl #(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  vrased_rst_ctrl_if.slave  bus
);

  localparam int unsigned TMR_W = 8;
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(FETCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD       = 2'd1,
    WAIT_FETCH = 2'd2,
    BAD        = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] hold_q, hold_d;
  logic [TMR_W-1:0] tmo_q, tmo_d;
  logic [5:0]       cause_q, cause_d;
  logic             fetch_to_q, fetch_to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             puc_q;

  // Saturating increment of the violation-event counter.
  always_comb begin
    cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and next-value logic for all registered outputs.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    tmo_d      = tmo_q;
    cause_d    = cause_q;
    fetch_to_d = fetch_to_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        // Clear is applied before any same-cycle violation is merged in.
        if (bus.cause_clr) begin
          cause_d    = '0;
          fetch_to_d = 1'b0;
        end
        if (bus.viol) begin
          state_d = HOLD;
          cause_d = cause_d | bus.viol_src;
          cnt_d   = cnt_inc_c;
          hold_d  = '0;
        end
      end
      HOLD: begin
        // A violation while holding extends the same event.
        if (bus.viol) begin
          cause_d = cause_q | bus.viol_src;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = WAIT_FETCH;
          tmo_d   = '0;
        end else begin
          hold_d = hold_q + TMR_W'(1);
        end
      end
      WAIT_FETCH: begin
        // Violation wins over a simultaneous restart observation.
        if (bus.viol) begin
          state_d = HOLD;
          cause_d = cause_q | bus.viol_src;
          cnt_d   = cnt_inc_c;
          hold_d  = '0;
        end else if (bus.pc == RESET_HANDLER) begin
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d    = HOLD;
          fetch_to_d = 1'b1;
          hold_d     = '0;
        end else begin
          tmo_d = tmo_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = HOLD;
        hold_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      tmo_q      <= '0;
      cause_q    <= '0;
      fetch_to_q <= 1'b0;
      cnt_q      <= '0;
      puc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      tmo_q      <= tmo_d;
      cause_q    <= cause_d;
      fetch_to_q <= fetch_to_d;
      cnt_q      <= cnt_d;
      puc_q      <= (state_d == HOLD);
    end
  end

  assign bus.puc_req  = puc_q;
  assign bus.cause    = cause_q;
  assign bus.fetch_to = fetch_to_q;
  assign bus.viol_cnt = cnt_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_vrased_rst_ctrl.sv
// Directed bench for vrased_rst_ctrl (CNT_W=2 so saturation is reachable).
module tb_vrased_rst_ctrl;

  localparam int unsigned CNT_W = 2;
  localparam logic [15:0] PC_RUN = 16'hA010;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  int   n;

  vrased_rst_ctrl_if #(.CNT_W(CNT_W)) bus ();

  vrased_rst_ctrl #(
    .RESET_HANDLER (16'h0000),
    .HOLD_CYCLES   (8),
    .FETCH_TIMEOUT (16),
    .CNT_W         (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.viol      = 1'b0;
    bus.viol_src  = 6'b0;
    bus.pc        = PC_RUN;
    bus.cause_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  // Wait (bounded) until the FSM reports the given state.
  task automatic wait_state(input string tag, input logic [1:0] s);
    int k;
    k = 0;
    while (bus.state != s && k < 100) begin
      cyc();
      k++;
    end
    check(tag, 32'(bus.state), 32'(s));
  endtask

  // One complete violation event that ends with a confirmed restart.
  task automatic one_event(input logic [5:0] src);
    bus.viol     = 1'b1;
    bus.viol_src = src;
    cyc();
    bus.viol     = 1'b0;
    bus.viol_src = 6'b0;
    wait_state("ev_wait_fetch", 2'd2);
    bus.pc = 16'h0000;
    cyc();
    bus.pc = PC_RUN;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    errors = 0;
    checks = 0;
    do_reset();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_puc", 32'(bus.puc_req), 32'd0);
    check("rst_cause", 32'(bus.cause), 32'd0);
    check("rst_fetch_to", 32'(bus.fetch_to), 32'd0);
    check("rst_cnt", 32'(bus.viol_cnt), 32'd0);

    // Single pulse: 8-cycle PUC, then restart three cycles after release.
    bus.viol     = 1'b1;
    bus.viol_src = 6'b000010;
    cyc();
    bus.viol     = 1'b0;
    bus.viol_src = 6'b0;
    check("t1_latency_puc", 32'(bus.puc_req), 32'd1);
    check("t1_state_hold", 32'(bus.state), 32'd1);
    n = 0;
    while (bus.puc_req && n < 100) begin
      n++;
      cyc();
    end
    check("t1_puc_len", 32'(n), 32'd8);
    check("t1_state_wf", 32'(bus.state), 32'd2);
    check("t1_cause", 32'(bus.cause), 32'h02);
    check("t1_cnt", 32'(bus.viol_cnt), 32'd1);
    repeat (3) cyc();
    check("t1_still_wf", 32'(bus.state), 32'd2);
    bus.pc = 16'h0000;
    cyc();
    bus.pc = PC_RUN;
    check("t1_idle", 32'(bus.state), 32'd0);

    // Violation during HOLD extends the pulse to 13 cycles, same event.
    do_reset();
    bus.viol     = 1'b1;
    bus.viol_src = 6'b000001;
    cyc();
    bus.viol     = 1'b0;
    bus.viol_src = 6'b0;
    n = 0;
    repeat (4) begin
      n += int'(bus.puc_req);
      cyc();
    end
    bus.viol     = 1'b1;
    bus.viol_src = 6'b010000;
    n += int'(bus.puc_req);
    cyc();
    bus.viol     = 1'b0;
    bus.viol_src = 6'b0;
    while (bus.puc_req && n < 100) begin
      n++;
      cyc();
    end
    check("t2_puc_len", 32'(n), 32'd13);
    check("t2_cause", 32'(bus.cause), 32'h11);
    check("t2_cnt", 32'(bus.viol_cnt), 32'd1);

    // Fetch timeout: 16 cycles in WAIT_FETCH, then an 8-cycle retry pulse.
    n = 0;
    while (bus.state == 2'd2 && n < 100) begin
      n++;
      cyc();
    end
    check("t3_wait_len", 32'(n), 32'd16);
    check("t3_fetch_to", 32'(bus.fetch_to), 32'd1);
    check("t3_puc_retry", 32'(bus.puc_req), 32'd1);
    check("t3_cnt_same", 32'(bus.viol_cnt), 32'd1);
    n = 0;
    while (bus.puc_req && n < 100) begin
      n++;
      cyc();
    end
    check("t3_retry_len", 32'(n), 32'd8);
    bus.pc = 16'h0000;
    cyc();
    bus.pc = PC_RUN;
    check("t3_idle", 32'(bus.state), 32'd0);
    check("t3_fetch_to_sticky", 32'(bus.fetch_to), 32'd1);

    // Clear together with a violation in IDLE: clear first, then merge.
    bus.cause_clr = 1'b1;
    bus.viol      = 1'b1;
    bus.viol_src  = 6'b000100;
    cyc();
    bus.cause_clr = 1'b0;
    bus.viol      = 1'b0;
    bus.viol_src  = 6'b0;
    check("t5_cause", 32'(bus.cause), 32'h04);
    check("t5_fetch_to", 32'(bus.fetch_to), 32'd0);
    check("t5_state", 32'(bus.state), 32'd1);
    check("t5_cnt", 32'(bus.viol_cnt), 32'd2);

    // Violation beats a simultaneous PC match in WAIT_FETCH.
    wait_state("t4_reach_wf", 2'd2);
    bus.viol     = 1'b1;
    bus.viol_src = 6'b100000;
    bus.pc       = 16'h0000;
    cyc();
    bus.viol     = 1'b0;
    bus.viol_src = 6'b0;
    bus.pc       = PC_RUN;
    check("t4_state", 32'(bus.state), 32'd1);
    check("t4_cnt", 32'(bus.viol_cnt), 32'd3);
    check("t4_cause", 32'(bus.cause), 32'h24);

    // Clear is ignored while holding, honoured in IDLE.
    bus.cause_clr = 1'b1;
    cyc();
    bus.cause_clr = 1'b0;
    check("t5_clr_in_hold", 32'(bus.cause), 32'h24);
    wait_state("t5_reach_wf", 2'd2);
    bus.pc = 16'h0000;
    cyc();
    bus.pc = PC_RUN;
    check("t5_idle", 32'(bus.state), 32'd0);
    bus.cause_clr = 1'b1;
    cyc();
    bus.cause_clr = 1'b0;
    check("t5_clr_idle", 32'(bus.cause), 32'h00);
    check("t5_clr_stay_idle", 32'(bus.state), 32'd0);

    // Five separate events saturate a 2-bit counter at 3.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      one_event(6'(1 << i));
    end
    check("t6_sat_cnt", 32'(bus.viol_cnt), 32'd3);
    check("t6_cause", 32'(bus.cause), 32'h1f);

    // Asynchronous reset mid-HOLD clears outputs before the next edge.
    bus.viol     = 1'b1;
    bus.viol_src = 6'b001000;
    cyc();
    bus.viol     = 1'b0;
    bus.viol_src = 6'b0;
    cyc();
    check("t7_in_hold", 32'(bus.puc_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t7_rst_puc", 32'(bus.puc_req), 32'd0);
    check("t7_rst_cause", 32'(bus.cause), 32'd0);
    check("t7_rst_cnt", 32'(bus.viol_cnt), 32'd0);
    check("t7_rst_state", 32'(bus.state), 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    check("t7_post_idle", 32'(bus.state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
